// File: rtl/truth_table_checker_pkg.sv
// rtl/truth_table_checker_pkg.sv - shared widths, state encoding and golden truth tables
package truth_table_checker_pkg;

  localparam int IDX_W = 2;
  localparam int CNT_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SETTLE = ST_SETTLE,
    S_SAMPLE = ST_SAMPLE,
    S_FINISH = ST_FINISH
  } state_t;

  // Truth tables are indexed by {x,y}
  localparam logic [3:0] TT_F4   = 4'b1101;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_OR   = 4'b1110;

  function automatic logic expect_bit(input logic [3:0] tt, input logic [IDX_W-1:0] idx);
    return tt[idx];
  endfunction

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// rtl/truth_table_checker_settle_timer.sv - loadable down-counter with zero flag
module settle_timer
  import truth_table_checker_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load has priority; otherwise count down and park at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - exhaustive two-input cell checker with pass/fail accumulation
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter logic [3:0] EXPECT = TT_F4,
  parameter int          SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       r_a,
  input  logic       r_b,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] err_map
);

  // Counter starts at SETTLE-1 so the SETTLE state lasts exactly SETTLE cycles
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             timer_load;
  logic             timer_zero;
  logic             fail_now;
  logic [2:0]       err_count_next;

  assign timer_load     = ((state == S_IDLE) && start) ||
                          ((state == S_SAMPLE) && (idx != 2'd3));
  assign fail_now       = (r_a != expect_bit(EXPECT, idx)) ||
                          (r_b != expect_bit(EXPECT, idx));
  assign err_count_next = err_count + {2'b00, fail_now};

  settle_timer u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (RELOAD),
    .zero       (timer_zero)
  );

  // Run sequencing, stimulus drive and result accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      x         <= 1'b0;
      y         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      err_map   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_SETTLE;
            idx       <= '0;
            x         <= 1'b0;
            y         <= 1'b0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= '0;
            err_map   <= '0;
          end
        end
        S_SETTLE: begin
          if (timer_zero) begin
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          err_count <= err_count_next;
          if (fail_now) begin
            err_map[idx] <= 1'b1;
          end
          if (idx == 2'd3) begin
            state <= S_FINISH;
            done  <= 1'b1;
            pass  <= (err_count_next == 3'd0);
          end else begin
            idx    <= idx + 2'd1;
            {x, y} <= idx + 2'd1;
            state  <= S_SETTLE;
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - scoreboard bench for truth_table_checker
module tb_truth_table_checker;
  import truth_table_checker_pkg::*;

  typedef struct {
    logic [3:0] map;
    logic [2:0] cnt;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, start3;
  logic [1:0] mode_a, mode_b;

  logic       x, y, busy, done, pass, r_a, r_b;
  logic [2:0] err_count;
  logic [3:0] err_map;
  logic       x3, y3, busy3, done3, pass3, r_a3, r_b3;
  logic [2:0] err_count3;
  logic [3:0] err_map3;

  exp_t q1[$];
  exp_t q3[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Behavioural cells: 0 = x|~y (correct), 1 = stuck-at-0, 2 = nand
  function automatic logic model(input logic [1:0] m, input logic a, input logic b);
    case (m)
      2'd0:    return a | ~b;
      2'd1:    return 1'b0;
      2'd2:    return ~(a & b);
      default: return 1'b1;
    endcase
  endfunction

  assign r_a  = model(mode_a, x, y);
  assign r_b  = model(mode_b, x, y);
  assign r_a3 = model(mode_a, x3, y3);
  assign r_b3 = model(mode_b, x3, y3);

  truth_table_checker #(.EXPECT(TT_F4), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .r_a(r_a), .r_b(r_b),
    .x(x), .y(y), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .err_map(err_map)
  );

  truth_table_checker #(.EXPECT(TT_F4), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .r_a(r_a3), .r_b(r_b3),
    .x(x3), .y(y3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err_count3), .err_map(err_map3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard for the SETTLE=1 instance
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      if (q1.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        check("err_map", err_map, e.map);
        check("err_count", err_count, e.cnt);
        check("pass", pass, e.pass);
      end
    end
  end

  // Scoreboard for the SETTLE=3 instance
  always @(negedge clk) begin
    if (!rst && done3) begin
      exp_t e;
      if (q3.size() == 0) begin
        check("unexpected_done3", 32'd1, 32'd0);
      end else begin
        e = q3.pop_front();
        check("err_map3", err_map3, e.map);
        check("err_count3", err_count3, e.cnt);
        check("pass3", pass3, e.pass);
      end
    end
  end

  task automatic run1(input logic [1:0] ma, input logic [1:0] mb,
                      input logic [3:0] emap, input logic [2:0] ecnt, input bit extra);
    exp_t e;
    mode_a = ma;
    mode_b = mb;
    e.map = emap; e.cnt = ecnt; e.pass = (ecnt == 3'd0);
    q1.push_back(e);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) @(negedge clk);
      start = extra && (k == 3 || k == 6);
      if (k == 0) begin
        check("clr_count", err_count, 0);
        check("clr_map", err_map, 0);
        check("clr_pass", pass, 0);
      end
      if (k < 8) check("xy_seq", {x, y}, k / 2);
      check("done_timing", done, k == 8);
      check("busy_timing", busy, k <= 8);
    end
    start = 1'b0;
    check("xy_hold", {x, y}, 3);
  endtask

  task automatic run3(input logic [1:0] ma, input logic [1:0] mb,
                      input logic [3:0] emap, input logic [2:0] ecnt);
    exp_t e;
    mode_a = ma;
    mode_b = mb;
    e.map = emap; e.cnt = ecnt; e.pass = (ecnt == 3'd0);
    q3.push_back(e);
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 16) check("xy_seq3", {x3, y3}, k / 4);
      check("done_timing3", done3, k == 16);
      check("busy_timing3", busy3, k <= 16);
    end
  endtask

  initial begin
    exp_t e;
    int   dn;
    int   kd[2];
    rst = 1'b1; start = 1'b0; start3 = 1'b0; mode_a = 2'd0; mode_b = 2'd0;
    repeat (2) @(negedge clk);
    check("reset_outs", {x, y, busy, done, pass, err_count, err_map}, 0);
    check("reset_outs3", {x3, y3, busy3, done3, pass3, err_count3, err_map3}, 0);
    rst = 1'b0;
    @(negedge clk);

    run1(2'd0, 2'd0, 4'b0000, 3'd0, 1'b0);
    run1(2'd0, 2'd1, 4'b1101, 3'd3, 1'b0);
    run1(2'd2, 2'd0, 4'b1010, 3'd2, 1'b0);
    run1(2'd2, 2'd1, 4'b1111, 3'd4, 1'b1);
    run1(2'd0, 2'd0, 4'b0000, 3'd0, 1'b1);

    // Reset during SETTLE of combination 2
    mode_a = 2'd0; mode_b = 2'd1;
    e.map = 4'b1101; e.cnt = 3'd3; e.pass = 1'b0;
    q1.push_back(e);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_xy", {x, y}, 2);
    rst = 1'b1;
    #1;
    check("midrun_reset", {x, y, busy, done, pass, err_count, err_map}, 0);
    q1.delete();
    @(negedge clk); rst = 1'b0;
    run1(2'd0, 2'd0, 4'b0000, 3'd0, 1'b0);

    // Start held high: back-to-back runs, second with DUT B fixed
    mode_a = 2'd0; mode_b = 2'd1;
    e.map = 4'b1101; e.cnt = 3'd3; e.pass = 1'b0;
    q1.push_back(e);
    e.map = 4'b0000; e.cnt = 3'd0; e.pass = 1'b1;
    q1.push_back(e);
    dn = 0; kd[0] = -1; kd[1] = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 9) mode_b = 2'd0;
      if (k == 10) start = 1'b0;
      if (done) begin
        if (dn < 2) kd[dn] = k;
        dn++;
      end
    end
    check("b2b_done_count", dn, 2);
    check("b2b_first_done", kd[0], 8);
    check("b2b_second_done", kd[1], 18);

    // Longer settle time, same DUT behaviours
    run3(2'd0, 2'd0, 4'b0000, 3'd0);
    run3(2'd0, 2'd1, 4'b1101, 3'd3);

    repeat (3) @(negedge clk);
    check("q1_drained", q1.size(), 0);
    check("q3_drained", q3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
